id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between decode/register-file read and execute in the pipelined mySoC core.
- Captures register-file read data (rd_1/rd_2), sign-extended immediate, PC values and decode controls into the EX stage.
- Resolves data hazards in front of the register file. This covers EX/MEM/WB operand forwarding, including the WB same-cycle write that the RF does not bypass.
- Detects load-use hazards and inserts a one-cycle bubble; honours downstream backpressure and branch flush.

Parameters:
- CNT_W, 16, width of the saturating load-use stall counter.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode holds a valid instruction
id_inst  in  32  instruction; rs1=[19:15], rs2=[24:20], rd=[11:7]
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd1  in  32  RF read data for rs1
id_rd2  in  32  RF read data for rs2
id_sext  in  32  sign-extended immediate
id_pc  in  32  instruction PC
id_pc_4  in  32  PC+4
id_rf_we  in  1  writes a register
id_rf_wsel  in  3  writeback select, encodings from defines.vh (WB_ALU/WB_EXT/WB_DRAM/WB_PC4)
id_alu_op  in  4  ALU operation
id_alub_sel  in  1  ALU B source: 0=op2, 1=sext
id_ram_we  in  1  store
id_ready  out  1  stage accepts the decode instruction this cycle
ex_ready  in  1  EX accepts current contents
flush  in  1  kill ID and EX contents (taken branch/jump)
ex_fwd_data  in  32  EX result for the instruction in this stage's output (non-DRAM wsel)
mem_fwd_we  in  1  MEM-stage instruction writes rd
mem_fwd_rd  in  5  MEM-stage destination
mem_fwd_data  in  32  MEM-stage writeback value
wb_we  in  1  WB register-file write enable
wb_rd  in  5  WB destination
wb_data  in  32  WB data (RF wD)
ex_valid  out  1  output holds a valid instruction
ex_pc, ex_pc_4, ex_op1, ex_op2, ex_sext  out  32 each  registered operands/values
ex_rd  out  5  destination
ex_rf_we, ex_alub_sel, ex_ram_we  out  1 each  registered controls
ex_rf_wsel  out  3  registered writeback select
ex_alu_op  out  4  registered ALU op
stall_cnt  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (rst_n low, asynchronous): every output register is 0, including ex_valid and stall_cnt. id_ready is combinational and reads 1 while ex_valid=0.
- Operand select for rs1 and rs2, combinational, priority high to low:
  - (a) index 0 gives 0.
  - (b) EX match: ex_valid, ex_rf_we, ex_rd==idx and wsel!=WB_DRAM gives ex_fwd_data.
  - (c) mem_fwd_we and mem_fwd_rd==idx gives mem_fwd_data.
  - (d) wb_we and wb_rd==idx gives wb_data.
  - (e) otherwise RF data.
- Load-use hazard (lu): id_valid, ex_valid, ex_rf_we, ex_rf_wsel==WB_DRAM, ex_rd!=0, and (id_use_rs1 with rs1==ex_rd, or id_use_rs2 with rs2==ex_rd).
- advance = !ex_valid || ex_ready.
- id_ready = flush || (advance && !lu).
- Per rising edge, first match wins:
  - flush: ex_valid<=0 and the ID instruction is discarded. Flush wins over lu and ex_ready=0.
  - !advance: all outputs hold. ex_ready=0 is a global freeze, so MEM/WB forwarding sources are frozen too.
  - lu: ex_valid<=0 (bubble) and stall_cnt increments, saturating at all-ones. The ID instruction is retried the next cycle and then takes its rs value from MEM.
  - otherwise: load all ex_* from id_* and forwarded operands; ex_valid<=id_valid; ex_rd<=inst[11:7].
- Bubbles (ex_valid=0) force ex_rf_we=0 and ex_ram_we=0. Other fields are don't-care but deterministic.
- Latency: one cycle from ID to EX. A load-use adds exactly one bubble.

Test Plan:
- Reset mid-run: assert rst_n=0 with ex_valid=1 -> all outputs 0 immediately (no clock edge needed); id_ready=1.
- Back-to-back ALU chain: `addi x5,x0,7` then `add x6,x5,x5`, ex_fwd_data=7 -> ex_op1=ex_op2=7, no bubble, stall_cnt=0.
- WB bypass: wb_we=1, wb_rd=3, wb_data=0xDEADBEEF, id_rd1=0 (stale), rs1=3 -> ex_op1=0xDEADBEEF.
- Load-use: `lw x8,0(x1)` in EX, then `add x9,x8,x2` in ID -> one bubble, id_ready=0 for one cycle, stall_cnt=1. Next cycle mem_fwd_rd=8, mem_fwd_data=0x55 -> ex_op1=0x55.
- x0 and priority:
  - rs1=0 with wb_rd=0, wb_data=0x1234 -> ex_op1=0.
  - EX, MEM and WB all match rd=4 with values 1, 2, 3 -> ex_op1=1.
- Flush vs stall: flush=1 together with lu=1 and ex_ready=0 -> next cycle ex_valid=0, stall_cnt unchanged.
- Backpressure: ex_ready=0 for 3 cycles -> outputs stable and id_ready=0. With stall_cnt preloaded to 0xFFFF, a further lu -> counter stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side inputs, forwarding sources, EX handshake
// and the registered EX-stage view. The master drives decode and the pipeline
// context. The slave is the id_ex_stage register itself.
interface id_ex_stage_if #(
  parameter int CNT_W = 16
);
  // decode side
  logic              id_valid;
  logic [31:0]       id_inst;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [31:0]       id_rd1;
  logic [31:0]       id_rd2;
  logic [31:0]       id_sext;
  logic [31:0]       id_pc;
  logic [31:0]       id_pc_4;
  logic              id_rf_we;
  logic [2:0]        id_rf_wsel;
  logic [3:0]        id_alu_op;
  logic              id_alub_sel;
  logic              id_ram_we;
  logic              id_ready;
  // pipeline context
  logic              ex_ready;
  logic              flush;
  logic [31:0]       ex_fwd_data;
  logic              mem_fwd_we;
  logic [4:0]        mem_fwd_rd;
  logic [31:0]       mem_fwd_data;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  // registered EX view
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_pc_4;
  logic [31:0]       ex_op1;
  logic [31:0]       ex_op2;
  logic [31:0]       ex_sext;
  logic [4:0]        ex_rd;
  logic              ex_rf_we;
  logic              ex_alub_sel;
  logic              ex_ram_we;
  logic [2:0]        ex_rf_wsel;
  logic [3:0]        ex_alu_op;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_inst, id_use_rs1, id_use_rs2, id_rd1, id_rd2, id_sext,
           id_pc, id_pc_4, id_rf_we, id_rf_wsel, id_alu_op, id_alub_sel, id_ram_we,
           ex_ready, flush, ex_fwd_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
           wb_we, wb_rd, wb_data,
    input  id_ready, ex_valid, ex_pc, ex_pc_4, ex_op1, ex_op2, ex_sext, ex_rd,
           ex_rf_we, ex_alub_sel, ex_ram_we, ex_rf_wsel, ex_alu_op, stall_cnt
  );

  modport slave (
    input  id_valid, id_inst, id_use_rs1, id_use_rs2, id_rd1, id_rd2, id_sext,
           id_pc, id_pc_4, id_rf_we, id_rf_wsel, id_alu_op, id_alub_sel, id_ram_we,
           ex_ready, flush, ex_fwd_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
           wb_we, wb_rd, wb_data,
    output id_ready, ex_valid, ex_pc, ex_pc_4, ex_op1, ex_op2, ex_sext, ex_rd,
           ex_rf_we, ex_alub_sel, ex_ram_we, ex_rf_wsel, ex_alu_op, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with EX/MEM/WB operand forwarding, load-use bubble
// insertion, backpressure hold and branch flush. The counter records every
// load-use bubble and saturates instead of wrapping.
module id_ex_stage #(
  parameter int         CNT_W   = 16,
  parameter logic [2:0] WB_DRAM = 3'd2  // writeback-from-DRAM encoding of the core
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  logic              r_ex_valid;
  logic [31:0]       r_ex_pc;
  logic [31:0]       r_ex_pc_4;
  logic [31:0]       r_ex_op1;
  logic [31:0]       r_ex_op2;
  logic [31:0]       r_ex_sext;
  logic [4:0]        r_ex_rd;
  logic              r_ex_rf_we;
  logic              r_ex_alub_sel;
  logic              r_ex_ram_we;
  logic [2:0]        r_ex_rf_wsel;
  logic [3:0]        r_ex_alu_op;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic              w_ex_fwd_ok;
  logic [31:0]       w_op1;
  logic [31:0]       w_op2;
  logic              w_lu;
  logic              w_advance;

  // Operand select: x0, then youngest producer first (EX, MEM, WB), then RF.
  // WB must be bypassed here because the RF does not forward a same-cycle write.
  function automatic logic [31:0] f_fwd(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic        ex_ok,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_data,
    input logic        mem_we,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_data,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (idx == 5'd0)                  return 32'd0;
    else if (ex_ok && ex_rd == idx)   return ex_data;
    else if (mem_we && mem_rd == idx) return mem_data;
    else if (wb_we && wb_rd == idx)   return wb_data;
    else                              return rf_data;
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_rs1 = bus.id_inst[19:15];
  assign w_rs2 = bus.id_inst[24:20];

  // A load in EX has no data yet, so it is never an EX forwarding source.
  assign w_ex_fwd_ok = r_ex_valid && r_ex_rf_we && (r_ex_rf_wsel != WB_DRAM);

  assign w_op1 = f_fwd(w_rs1, bus.id_rd1, w_ex_fwd_ok, r_ex_rd, bus.ex_fwd_data,
                       bus.mem_fwd_we, bus.mem_fwd_rd, bus.mem_fwd_data,
                       bus.wb_we, bus.wb_rd, bus.wb_data);
  assign w_op2 = f_fwd(w_rs2, bus.id_rd2, w_ex_fwd_ok, r_ex_rd, bus.ex_fwd_data,
                       bus.mem_fwd_we, bus.mem_fwd_rd, bus.mem_fwd_data,
                       bus.wb_we, bus.wb_rd, bus.wb_data);

  assign w_lu = bus.id_valid && r_ex_valid && r_ex_rf_we &&
                (r_ex_rf_wsel == WB_DRAM) && (r_ex_rd != 5'd0) &&
                ((bus.id_use_rs1 && (w_rs1 == r_ex_rd)) ||
                 (bus.id_use_rs2 && (w_rs2 == r_ex_rd)));

  assign w_advance    = !r_ex_valid || bus.ex_ready;
  // Flush discards the ID instruction, so it counts as consumed.
  assign bus.id_ready = bus.flush || (w_advance && !w_lu);

  // EX register: flush > hold on backpressure > load-use bubble > load from ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_pc_4     <= '0;
      r_ex_op1      <= '0;
      r_ex_op2      <= '0;
      r_ex_sext     <= '0;
      r_ex_rd       <= '0;
      r_ex_rf_we    <= 1'b0;
      r_ex_alub_sel <= 1'b0;
      r_ex_ram_we   <= 1'b0;
      r_ex_rf_wsel  <= '0;
      r_ex_alu_op   <= '0;
      r_stall_cnt   <= '0;
    end else if (bus.flush) begin
      r_ex_valid  <= 1'b0;
      r_ex_rf_we  <= 1'b0;
      r_ex_ram_we <= 1'b0;
    end else if (w_advance) begin
      if (w_lu) begin
        r_ex_valid  <= 1'b0;
        r_ex_rf_we  <= 1'b0;
        r_ex_ram_we <= 1'b0;
        r_stall_cnt <= f_sat_inc(r_stall_cnt);
      end else begin
        r_ex_valid    <= bus.id_valid;
        r_ex_pc       <= bus.id_pc;
        r_ex_pc_4     <= bus.id_pc_4;
        r_ex_op1      <= w_op1;
        r_ex_op2      <= w_op2;
        r_ex_sext     <= bus.id_sext;
        r_ex_rd       <= bus.id_inst[11:7];
        r_ex_rf_we    <= bus.id_valid && bus.id_rf_we;
        r_ex_alub_sel <= bus.id_alub_sel;
        r_ex_ram_we   <= bus.id_valid && bus.id_ram_we;
        r_ex_rf_wsel  <= bus.id_rf_wsel;
        r_ex_alu_op   <= bus.id_alu_op;
      end
    end
  end

  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_pc       = r_ex_pc;
  assign bus.ex_pc_4     = r_ex_pc_4;
  assign bus.ex_op1      = r_ex_op1;
  assign bus.ex_op2      = r_ex_op2;
  assign bus.ex_sext     = r_ex_sext;
  assign bus.ex_rd       = r_ex_rd;
  assign bus.ex_rf_we    = r_ex_rf_we;
  assign bus.ex_alub_sel = r_ex_alub_sel;
  assign bus.ex_ram_we   = r_ex_ram_we;
  assign bus.ex_rf_wsel  = r_ex_rf_wsel;
  assign bus.ex_alu_op   = r_ex_alu_op;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: forwarding vector table, hand-written hazard
// sequences and a randomized run, all compared against a reference model.
// The counter is built narrow so saturation is reachable in a few cycles.
module tb_id_ex_stage;
  localparam int         CNT_W   = 4;
  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_DRAM = 3'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.CNT_W(CNT_W)) bus ();
  id_ex_stage #(.CNT_W(CNT_W), .WB_DRAM(WB_DRAM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic             valid;
    logic [31:0]      pc, pc_4, op1, op2, sext;
    logic [4:0]       rd;
    logic             rf_we, alub_sel, ram_we;
    logic [2:0]       wsel;
    logic [3:0]       alu_op;
    logic [CNT_W-1:0] cnt;
  } ex_t;

  typedef struct {
    logic [4:0]  p_rd;  logic [2:0] p_wsel; logic p_we;
    logic [31:0] exf;
    logic        mwe;   logic [4:0] mrd;    logic [31:0] mdat;
    logic        wwe;   logic [4:0] wrd;    logic [31:0] wdat;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [31:0] rd1, rd2;
    logic        e_ready, e_valid, e_ops;
    logic [31:0] e_op1, e_op2;
  } vec_t;

  ex_t m;
  int  n_checks = 0;
  int  n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  // Reference: the youngest in-flight writer of a register supplies its value.
  // EX cannot supply a load result; x0 always reads zero.
  function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rf);
    logic        hit [3];
    logic [31:0] val [3];
    if (idx == 0) return 32'd0;
    hit[0] = m.valid && m.rf_we && (m.rd == idx) && (m.wsel != WB_DRAM);
    val[0] = bus.ex_fwd_data;
    hit[1] = bus.mem_fwd_we && (bus.mem_fwd_rd == idx);
    val[1] = bus.mem_fwd_data;
    hit[2] = bus.wb_we && (bus.wb_rd == idx);
    val[2] = bus.wb_data;
    for (int i = 0; i < 3; i++) if (hit[i]) return val[i];
    return rf;
  endfunction

  function automatic logic ref_lu();
    logic [4:0] r1 = bus.id_inst[19:15];
    logic [4:0] r2 = bus.id_inst[24:20];
    logic       pending_load = m.valid && m.rf_we && (m.wsel == WB_DRAM) && (m.rd != 0);
    return bus.id_valid && pending_load &&
           ((bus.id_use_rs1 && r1 == m.rd) || (bus.id_use_rs2 && r2 == m.rd));
  endfunction

  function automatic logic ref_ready();
    return bus.flush || ((!m.valid || bus.ex_ready) && !ref_lu());
  endfunction

  task automatic cmp_all();
    chk("ex_valid",  bus.ex_valid,  m.valid);
    chk("ex_rf_we",  bus.ex_rf_we,  m.rf_we);
    chk("ex_ram_we", bus.ex_ram_we, m.ram_we);
    chk("stall_cnt", bus.stall_cnt, m.cnt);
    if (m.valid) begin
      chk("ex_pc",       bus.ex_pc,       m.pc);
      chk("ex_pc_4",     bus.ex_pc_4,     m.pc_4);
      chk("ex_op1",      bus.ex_op1,      m.op1);
      chk("ex_op2",      bus.ex_op2,      m.op2);
      chk("ex_sext",     bus.ex_sext,     m.sext);
      chk("ex_rd",       bus.ex_rd,       m.rd);
      chk("ex_alub_sel", bus.ex_alub_sel, m.alub_sel);
      chk("ex_rf_wsel",  bus.ex_rf_wsel,  m.wsel);
      chk("ex_alu_op",   bus.ex_alu_op,   m.alu_op);
    end
  endtask

  // One clock: check id_ready, predict the next EX contents, clock, compare.
  task automatic step();
    ex_t  nx;
    logic lu;
    #1;
    chk("id_ready", bus.id_ready, ref_ready());
    lu = ref_lu();
    nx = m;
    if (bus.flush) begin
      nx.valid = 1'b0; nx.rf_we = 1'b0; nx.ram_we = 1'b0;
    end else if (m.valid && !bus.ex_ready) begin
      nx = m;
    end else if (lu) begin
      nx.valid = 1'b0; nx.rf_we = 1'b0; nx.ram_we = 1'b0;
      if (m.cnt != CNT_MAX) nx.cnt = m.cnt + 1'b1;
    end else begin
      nx.valid    = bus.id_valid;
      nx.pc       = bus.id_pc;
      nx.pc_4     = bus.id_pc_4;
      nx.op1      = ref_operand(bus.id_inst[19:15], bus.id_rd1);
      nx.op2      = ref_operand(bus.id_inst[24:20], bus.id_rd2);
      nx.sext     = bus.id_sext;
      nx.rd       = bus.id_inst[11:7];
      nx.rf_we    = bus.id_valid && bus.id_rf_we;
      nx.alub_sel = bus.id_alub_sel;
      nx.ram_we   = bus.id_valid && bus.id_ram_we;
      nx.wsel     = bus.id_rf_wsel;
      nx.alu_op   = bus.id_alu_op;
    end
    @(posedge clk);
    m = nx;
    #1;
    cmp_all();
  endtask

  task automatic clear_side();
    bus.ex_ready = 1'b1; bus.flush = 1'b0; bus.ex_fwd_data = '0;
    bus.mem_fwd_we = 1'b0; bus.mem_fwd_rd = '0; bus.mem_fwd_data = '0;
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic we, input logic [2:0] wsel);
    bus.id_valid = v; bus.id_inst = mk_inst(rd, rs1, rs2);
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
    bus.id_rd1 = d1; bus.id_rd2 = d2;
    bus.id_pc = $urandom & 32'hFFFF_FFFC; bus.id_pc_4 = bus.id_pc + 32'd4;
    bus.id_sext = $urandom; bus.id_alu_op = 4'($urandom_range(0, 15));
    bus.id_alub_sel = 1'($urandom_range(0, 1)); bus.id_ram_we = 1'b0;
    bus.id_rf_we = we; bus.id_rf_wsel = wsel;
  endtask

  // Asynchronous reset between clock edges: outputs must clear with no edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m = '{default: '0};
    chk("rst_ex_valid",  bus.ex_valid,  0);
    chk("rst_ex_op1",    bus.ex_op1,    0);
    chk("rst_ex_op2",    bus.ex_op2,    0);
    chk("rst_ex_pc",     bus.ex_pc,     0);
    chk("rst_ex_rd",     bus.ex_rd,     0);
    chk("rst_ex_rf_we",  bus.ex_rf_we,  0);
    chk("rst_ex_alu_op", bus.ex_alu_op, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_id_ready",  bus.id_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vt [10];

  initial begin
    clear_side();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, WB_ALU);
    m = '{default: '0};
    do_reset();

    // ---------------- forwarding / hazard vector table ----------------
    //         p_rd p_wsel  p_we exf          mwe mrd mdat  wwe wrd wdat           rs1 rs2 u1 u2 rd1      rd2      rdy vld ops op1            op2
    vt[0] = '{5,  WB_ALU,  1, 32'd7,       0, 0, 0,      0, 0,  0,             5,  5,  1, 1, 0,       0,       1,  1,  1,  32'd7,         32'd7};
    vt[1] = '{10, WB_ALU,  1, 32'h11,      0, 0, 0,      1, 3,  32'hDEADBEEF,  3,  0,  1, 1, 0,       32'h99,  1,  1,  1,  32'hDEADBEEF,  0};
    vt[2] = '{0,  WB_ALU,  1, 32'hAAAA,    0, 0, 0,      1, 0,  32'h1234,      0,  0,  1, 1, 32'h5555,32'h6666,1,  1,  1,  0,             0};
    vt[3] = '{4,  WB_ALU,  1, 32'd1,       1, 4, 32'd2,  1, 4,  32'd3,         4,  4,  1, 1, 0,       0,       1,  1,  1,  32'd1,         32'd1};
    vt[4] = '{7,  WB_ALU,  1, 32'd1,       1, 4, 32'd2,  1, 4,  32'd3,         4,  9,  1, 1, 0,       32'h77,  1,  1,  1,  32'd2,         32'h77};
    vt[5] = '{8,  WB_DRAM, 1, 32'hBAD,     0, 0, 0,      0, 0,  0,             8,  2,  1, 1, 0,       0,       0,  0,  0,  0,             0};
    vt[6] = '{8,  WB_DRAM, 1, 32'hBAD,     0, 0, 0,      0, 0,  0,             8,  0,  0, 0, 32'h31,  0,       1,  1,  1,  32'h31,        0};
    vt[7] = '{6,  WB_ALU,  0, 32'hF00,     0, 0, 0,      0, 0,  0,             6,  6,  1, 1, 32'h66,  32'h67,  1,  1,  1,  32'h66,        32'h67};
    vt[8] = '{12, WB_DRAM, 1, 32'hBAD,     0, 0, 0,      0, 0,  0,             1,  12, 1, 1, 0,       0,       0,  0,  0,  0,             0};
    vt[9] = '{2,  WB_ALU,  1, 32'h2,       0, 0, 0,      1, 17, 32'hCAFE,      1,  17, 1, 1, 32'h1,   0,       1,  1,  1,  32'h1,         32'hCAFE};
    for (int i = 0; i < 10; i++) begin
      clear_side();
      drive_id(1, vt[i].p_rd, 0, 0, 0, 0, 0, 0, vt[i].p_we, vt[i].p_wsel);
      step();
      drive_id(1, 9, vt[i].rs1, vt[i].rs2, vt[i].u1, vt[i].u2, vt[i].rd1, vt[i].rd2, 1, WB_ALU);
      bus.ex_fwd_data = vt[i].exf;
      bus.mem_fwd_we = vt[i].mwe; bus.mem_fwd_rd = vt[i].mrd; bus.mem_fwd_data = vt[i].mdat;
      bus.wb_we = vt[i].wwe; bus.wb_rd = vt[i].wrd; bus.wb_data = vt[i].wdat;
      #1;
      chk($sformatf("vec%0d_id_ready", i), bus.id_ready, vt[i].e_ready);
      step();
      chk($sformatf("vec%0d_ex_valid", i), bus.ex_valid, vt[i].e_valid);
      if (vt[i].e_ops) begin
        chk($sformatf("vec%0d_op1", i), bus.ex_op1, vt[i].e_op1);
        chk($sformatf("vec%0d_op2", i), bus.ex_op2, vt[i].e_op2);
      end
    end

    // ---------------- ALU chain then load-use ----------------
    do_reset();
    clear_side();
    drive_id(1, 5, 0, 0, 1, 0, 0, 0, 1, WB_ALU);          // addi x5,x0,7
    step();
    drive_id(1, 6, 5, 5, 1, 1, 0, 0, 1, WB_ALU);          // add x6,x5,x5
    bus.ex_fwd_data = 32'd7;
    step();
    chk("chain_op1", bus.ex_op1, 7);
    chk("chain_op2", bus.ex_op2, 7);
    chk("chain_valid", bus.ex_valid, 1);
    chk("chain_cnt", bus.stall_cnt, 0);
    clear_side();
    drive_id(1, 8, 1, 0, 1, 0, 32'h100, 0, 1, WB_DRAM);   // lw x8,0(x1)
    step();
    drive_id(1, 9, 8, 2, 1, 1, 32'hBAD, 32'h22, 1, WB_ALU); // add x9,x8,x2
    #1;
    chk("lu_id_ready", bus.id_ready, 0);
    step();
    chk("lu_bubble", bus.ex_valid, 0);
    chk("lu_rf_we", bus.ex_rf_we, 0);
    chk("lu_cnt", bus.stall_cnt, 1);
    bus.mem_fwd_we = 1'b1; bus.mem_fwd_rd = 5'd8; bus.mem_fwd_data = 32'h55;
    #1;
    chk("lu_retry_ready", bus.id_ready, 1);
    step();
    chk("lu_retry_valid", bus.ex_valid, 1);
    chk("lu_retry_op1", bus.ex_op1, 32'h55);
    chk("lu_retry_op2", bus.ex_op2, 32'h22);
    chk("lu_retry_rd", bus.ex_rd, 9);
    chk("lu_retry_cnt", bus.stall_cnt, 1);

    // ---------------- flush beats load-use and backpressure ----------------
    do_reset();
    clear_side();
    drive_id(1, 8, 1, 0, 1, 0, 0, 0, 1, WB_DRAM);
    step();
    drive_id(1, 9, 8, 0, 1, 0, 0, 0, 1, WB_ALU);
    bus.ex_ready = 1'b0; bus.flush = 1'b1;
    #1;
    chk("flush_id_ready", bus.id_ready, 1);
    step();
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_cnt", bus.stall_cnt, 0);

    // ---------------- backpressure hold ----------------
    clear_side();
    drive_id(1, 11, 0, 0, 0, 0, 0, 0, 1, WB_ALU);
    bus.id_pc = 32'h400; bus.id_pc_4 = 32'h404;
    step();
    bus.ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_id(1, 13, 3, 4, 1, 1, $urandom, $urandom, 1, WB_ALU);
      bus.id_pc = 32'h500; bus.id_pc_4 = 32'h504;
      #1;
      chk("bp_id_ready", bus.id_ready, 0);
      step();
      chk("bp_pc_hold", bus.ex_pc, 32'h400);
      chk("bp_rd_hold", bus.ex_rd, 11);
      chk("bp_valid_hold", bus.ex_valid, 1);
    end
    bus.ex_ready = 1'b1;
    step();
    chk("bp_release_pc", bus.ex_pc, 32'h500);

    // ---------------- counter saturation ----------------
    do_reset();
    clear_side();
    for (int k = 0; k <= int'(CNT_MAX); k++) begin
      drive_id(1, 8, 0, 0, 0, 0, 0, 0, 1, WB_DRAM);
      step();
      drive_id(1, 9, 8, 0, 1, 0, 0, 0, 1, WB_ALU);
      step();
    end
    chk("sat_cnt", bus.stall_cnt, CNT_MAX);

    // ---------------- reset mid-run with valid contents ----------------
    drive_id(1, 14, 0, 0, 0, 0, 0, 0, 1, WB_ALU);
    step();
    chk("pre_rst_valid", bus.ex_valid, 1);
    do_reset();

    // ---------------- randomized run ----------------
    for (int c = 0; c < 400; c++) begin
      bus.id_valid     = 1'($urandom_range(0, 3) != 0);
      bus.id_inst      = mk_inst(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                 5'($urandom_range(0, 7)));
      bus.id_use_rs1   = 1'($urandom_range(0, 1));
      bus.id_use_rs2   = 1'($urandom_range(0, 1));
      bus.id_rd1       = $urandom; bus.id_rd2 = $urandom;
      bus.id_sext      = $urandom; bus.id_pc = $urandom; bus.id_pc_4 = $urandom;
      bus.id_rf_we     = 1'($urandom_range(0, 1));
      bus.id_rf_wsel   = 3'($urandom_range(0, 3));
      bus.id_alu_op    = 4'($urandom_range(0, 15));
      bus.id_alub_sel  = 1'($urandom_range(0, 1));
      bus.id_ram_we    = 1'($urandom_range(0, 1));
      bus.ex_ready     = 1'($urandom_range(0, 3) != 0);
      bus.flush        = 1'($urandom_range(0, 15) == 0);
      bus.ex_fwd_data  = $urandom;
      bus.mem_fwd_we   = 1'($urandom_range(0, 1));
      bus.mem_fwd_rd   = 5'($urandom_range(0, 7));
      bus.mem_fwd_data = $urandom;
      bus.wb_we        = 1'($urandom_range(0, 1));
      bus.wb_rd        = 5'($urandom_range(0, 7));
      bus.wb_data      = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
